ibex_axi_sram: RTL and testbench

IBEX_AXI_SRAM -- requirements
Module: ibex_axi_sram

---
 rtl/ibex_axi_pkg.sv | 72 +++++++
 rtl/ibex_axi_sram_addr_gen.sv | 32 +++
 rtl/ibex_axi_sram.sv | 190 +++++++++++++++++++
 tb/tb_ibex_axi_sram.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_axi_pkg.sv
// Shared definitions for the AXI4 SRAM slave.
// Contents: FSM state encoding, AXI response and burst codes, and the AXI
// request/response structs (32-bit addr/data, 4-bit ID, 1-bit user).
package ibex_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_RD_RESP,
    ST_WR_DATA,
    ST_WR_RESP
  } sram_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        user;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        user;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    axi_b_t  b;
    logic    b_valid;
    axi_r_t  r;
    logic    r_valid;
  } axi_rsp_t;

endpackage

// File: rtl/ibex_axi_sram_addr_gen.sv
// Beat address generator for the AXI SRAM slave.
// Ports:
//   start_addr_i  burst start byte address
//   burst_i       AXI burst type
//   size_i        AXI beat size
//   beat_i        beat index within the burst
//   addr_o        byte address of this beat (32-bit wrap-around for INCR)
//   err_o         beat is not serviceable (WRAP/reserved burst, size != 4 bytes,
//                 or address beyond the SRAM)
module ibex_axi_sram_addr_gen #(
  parameter int unsigned MemWords = 16384
) (
  input  logic [31:0] start_addr_i,
  input  logic [1:0]  burst_i,
  input  logic [2:0]  size_i,
  input  logic [7:0]  beat_i,
  output logic [31:0] addr_o,
  output logic        err_o
);
  import ibex_axi_pkg::*;

  // One extra bit so MemWords*4 == 2^32 still compares correctly.
  localparam logic [32:0] ByteLimit = 33'(MemWords) * 33'd4;

  always_comb begin
    addr_o = (burst_i == BURST_FIXED) ? start_addr_i
                                      : start_addr_i + {22'b0, beat_i, 2'b00};
    err_o  = (burst_i == BURST_WRAP) || (burst_i == 2'b11) || (size_i != 3'd2) ||
             ({1'b0, addr_o} >= ByteLimit);
  end

endmodule

// File: rtl/ibex_axi_sram.sv
// AXI4 slave in front of a single-port 32-bit SRAM, one transaction at a time.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   axi_req_i          AW/W/AR channels plus bready/rready
//   axi_rsp_o          awready/wready/arready plus B and R channels
//   sram_req_o         SRAM access strobe (read data returns one cycle later)
//   sram_we_o          SRAM write enable
//   sram_addr_o        SRAM word address
//   sram_wdata_o       SRAM write data
//   sram_be_o          SRAM byte enables
//   sram_rdata_i       SRAM read data
module ibex_axi_sram #(
  parameter type         axi_req_t = ibex_axi_pkg::axi_req_t,
  parameter type         axi_rsp_t = ibex_axi_pkg::axi_rsp_t,
  parameter int unsigned MemWords  = 16384
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  axi_req_t                    axi_req_i,
  output axi_rsp_t                    axi_rsp_o,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [$clog2(MemWords)-1:0] sram_addr_o,
  output logic [31:0]                 sram_wdata_o,
  output logic [3:0]                  sram_be_o,
  input  logic [31:0]                 sram_rdata_i
);
  import ibex_axi_pkg::*;

  localparam int AddrW = $clog2(MemWords);

  sram_state_e state_q, state_d;
  logic        prio_wr_q, prio_wr_d;  // 1: write wins the next AR/AW collision
  logic        en_q;                  // keeps the ready signals low while in reset
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        werr_q, werr_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;
  logic        rd_pend_q, rd_pend_d;  // first RD_RESP cycle: SRAM data is live on the bus
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] beat_addr;
  logic        beat_err;
  logic        last_beat;
  axi_rsp_t    rsp;

  ibex_axi_sram_addr_gen #(.MemWords(MemWords)) u_addr_gen (
    .start_addr_i (addr_q),
    .burst_i      (burst_q),
    .size_i       (size_q),
    .beat_i       (cnt_q),
    .addr_o       (beat_addr),
    .err_o        (beat_err)
  );

  assign last_beat    = (cnt_q == len_q);
  assign sram_addr_o  = beat_addr[AddrW+1:2];
  assign sram_wdata_o = axi_req_i.w.data;
  assign sram_be_o    = axi_req_i.w.strb;
  assign axi_rsp_o    = rsp;

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    werr_d    = werr_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rd_pend_d = 1'b0;
    // Capture the SRAM word in the cycle it is valid so R stays stable under stall.
    rdata_d   = rd_pend_q ? sram_rdata_i : rdata_q;
    sram_req_o = 1'b0;
    sram_we_o  = 1'b0;

    rsp        = '0;
    rsp.r.id   = id_q;
    rsp.r.data = rd_pend_q ? sram_rdata_i : rdata_q;
    rsp.r.resp = rresp_q;
    rsp.r.last = rlast_q;
    rsp.b.id   = id_q;
    rsp.b.resp = werr_q ? RESP_SLVERR : RESP_OKAY;

    unique case (state_q)
      ST_IDLE: begin
        rsp.ar_ready = en_q && !(axi_req_i.aw_valid && prio_wr_q);
        rsp.aw_ready = en_q && !(axi_req_i.ar_valid && !prio_wr_q);
        if (axi_req_i.ar_valid && rsp.ar_ready) begin
          id_d      = axi_req_i.ar.id;
          addr_d    = axi_req_i.ar.addr;
          len_d     = axi_req_i.ar.len;
          size_d    = axi_req_i.ar.size;
          burst_d   = axi_req_i.ar.burst;
          cnt_d     = '0;
          prio_wr_d = 1'b1;
          state_d   = ST_RD_ACC;
        end else if (axi_req_i.aw_valid && rsp.aw_ready) begin
          id_d      = axi_req_i.aw.id;
          addr_d    = axi_req_i.aw.addr;
          len_d     = axi_req_i.aw.len;
          size_d    = axi_req_i.aw.size;
          burst_d   = axi_req_i.aw.burst;
          cnt_d     = '0;
          werr_d    = 1'b0;
          prio_wr_d = 1'b0;
          state_d   = ST_WR_DATA;
        end
      end
      ST_RD_ACC: begin
        sram_req_o = !beat_err;
        rd_pend_d  = !beat_err;
        rresp_d    = beat_err ? RESP_SLVERR : RESP_OKAY;
        rlast_d    = last_beat;
        if (beat_err) rdata_d = '0;
        state_d    = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        rsp.r_valid = 1'b1;
        if (axi_req_i.r_ready) begin
          if (rlast_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_RD_ACC;
          end
        end
      end
      ST_WR_DATA: begin
        rsp.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          sram_req_o = !beat_err;
          sram_we_o  = 1'b1;
          // Length always comes from awlen; a misplaced wlast only poisons bresp.
          if (beat_err || (axi_req_i.w.last != last_beat)) werr_d = 1'b1;
          if (last_beat) state_d = ST_WR_RESP;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_WR_RESP: begin
        rsp.b_valid = 1'b1;
        if (axi_req_i.b_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b0;
      en_q      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      werr_q    <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      en_q      <= 1'b1;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      werr_q    <= werr_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ibex_axi_sram.sv
// Self-checking bench for ibex_axi_sram: an SRAM model, a transaction-level
// expectation model (queues of expected SRAM accesses, R beats and B responses),
// and one monitor that checks the DUT against those queues on every cycle.
module tb_ibex_axi_sram;
  import ibex_axi_pkg::*;

  localparam int unsigned MW = 1024;
  localparam int AW = $clog2(MW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  axi_req_t req;
  axi_rsp_t rsp;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [3:0]    sram_be;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_axi_sram #(.axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t), .MemWords(MW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_rsp_o(rsp),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata));

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  // SRAM model: read data valid exactly one cycle after the strobe, garbage otherwise.
  logic [31:0] mem [MW];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!rst_n && !loaded) begin
      for (int i = 0; i < int'(MW); i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (sram_req && sram_we) begin
      for (int i = 0; i < 4; i++)
        if (sram_be[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
    end
    if (sram_req && !sram_we) sram_rdata <= mem[sram_addr];
    else                      sram_rdata <= {16'hBAD0, cyc[15:0]};
  end

  // Expectation model
  typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] be; } sacc_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  sacc_t  sq[$];
  rbeat_t rq[$];
  bexp_t  bq[$];
  logic [31:0] ref_mem [MW];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
    return (burst == BURST_FIXED) ? a : a + 32'(4 * b);
  endfunction

  function automatic bit beat_bad(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size);
    return (burst == BURST_WRAP) || (burst == 2'b11) || (size != 3'd2) ||
           (longint'(addr) >= longint'(MW) * 4);
  endfunction

  task automatic model_read(input logic [3:0] id, input logic [31:0] a, input int len,
                            input logic [1:0] burst, input logic [2:0] size);
    for (int b = 0; b <= len; b++) begin
      logic [31:0] ad;
      ad = beat_addr(a, burst, b);
      if (beat_bad(ad, burst, size)) begin
        rq.push_back('{id, 32'h0, RESP_SLVERR, (b == len)});
      end else begin
        sq.push_back('{1'b0, ad[AW+1:2], 32'h0, 4'h0});
        rq.push_back('{id, ref_mem[ad[AW+1:2]], RESP_OKAY, (b == len)});
      end
    end
  endtask

  task automatic model_write(input logic [3:0] id, input logic [31:0] a, input int len,
                             input logic [1:0] burst, input logic [2:0] size);
    bit bad = 1'b0;
    for (int b = 0; b <= len; b++) begin
      logic [31:0] ad;
      ad = beat_addr(a, burst, b);
      if (beat_bad(ad, burst, size)) begin
        bad = 1'b1;
      end else begin
        sq.push_back('{1'b1, ad[AW+1:2], wd[b], ws[b]});
        for (int i = 0; i < 4; i++)
          if (ws[b][i]) ref_mem[ad[AW+1:2]][8*i +: 8] = wd[b][8*i +: 8];
      end
      if (wl[b] != (b == len)) bad = 1'b1;
    end
    bq.push_back('{id, bad ? RESP_SLVERR : RESP_OKAY});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %0s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %0s: actual=timeout required=handshake (t=%0t)", name, $time);
  endtask

  // Monitor
  int ar_cyc = 0, sreq_cyc = 0, rv_cyc = 0;
  logic rv_d = 1'b0;
  logic [31:0] last_rdata;
  logic [3:0]  last_rid, last_bid;
  logic [1:0]  last_rresp, last_bresp;
  logic        last_rlast;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp.r_valid && !rv_d) rv_cyc = cyc;
      rv_d = rsp.r_valid;
      if (rsp.r_valid || rsp.b_valid || rsp.w_ready)
        chk("no_accept_busy", {30'b0, rsp.ar_ready, rsp.aw_ready}, 32'h0);
      if (rsp.r_valid) begin
        if (rq.size() == 0) timeout("r_unexpected");
        else begin
          chk("rid", rsp.r.id, rq[0].id);
          chk("rresp", rsp.r.resp, rq[0].resp);
          chk("rlast", rsp.r.last, rq[0].last);
          chk("ruser", rsp.r.user, 0);
          if (rq[0].resp == RESP_OKAY) chk("rdata", rsp.r.data, rq[0].data);
          if (req.r_ready) begin
            last_rdata = rsp.r.data; last_rid = rsp.r.id;
            last_rresp = rsp.r.resp; last_rlast = rsp.r.last;
            void'(rq.pop_front());
          end
        end
      end
      if (rsp.b_valid) begin
        if (bq.size() == 0) timeout("b_unexpected");
        else begin
          chk("bid", rsp.b.id, bq[0].id);
          chk("bresp", rsp.b.resp, bq[0].resp);
          chk("buser", rsp.b.user, 0);
          if (req.b_ready) begin
            last_bid = rsp.b.id; last_bresp = rsp.b.resp;
            void'(bq.pop_front());
          end
        end
      end
      if (sram_req) begin
        if (!sram_we) sreq_cyc = cyc;
        if (sq.size() == 0) timeout("sram_unexpected");
        else begin
          chk("sram_we", sram_we, sq[0].we);
          chk("sram_addr", 32'(sram_addr), 32'(sq[0].addr));
          if (sq[0].we) begin
            chk("sram_wdata", sram_wdata, sq[0].data);
            chk("sram_be", sram_be, sq[0].be);
          end
          void'(sq.pop_front());
        end
      end
    end
  end

  // Drivers
  task automatic ar_wait();
    int k = 0;
    do begin @(negedge clk); k++; end while (!rsp.ar_ready && k < 50);
    if (!rsp.ar_ready) timeout("ar_handshake");
    else ar_cyc = cyc;
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic aw_wait();
    int k = 0;
    do begin @(negedge clk); k++; end while (!rsp.aw_ready && k < 50);
    if (!rsp.aw_ready) timeout("aw_handshake");
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input int len,
                        input logic [1:0] burst, input logic [2:0] size);
    req.ar = '{id, a, 8'(len), size, burst, 1'b0};
    req.ar_valid = 1'b1;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input int len,
                        input logic [1:0] burst, input logic [2:0] size);
    req.aw = '{id, a, 8'(len), size, burst, 1'b0};
    req.aw_valid = 1'b1;
  endtask

  task automatic r_collect(input int n, input bit toggle);
    int got = 0;
    int k = 0;
    while (got < n && k < 200) begin
      req.r_ready = toggle ? (k % 3 == 2) : 1'b1;
      @(negedge clk);
      if (rsp.r_valid && req.r_ready) got++;
      @(posedge clk); #1;
      k++;
    end
    req.r_ready = 1'b0;
    if (got < n) timeout("r_collect");
  endtask

  task automatic w_phase(input int len);
    for (int b = 0; b <= len; b++) begin
      int k = 0;
      req.w = '{wd[b], ws[b], wl[b], 1'b0};
      req.w_valid = 1'b1;
      do begin @(negedge clk); k++; end while (!rsp.w_ready && k < 50);
      if (!rsp.w_ready) timeout("w_handshake");
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0;
  endtask

  task automatic b_phase();
    int k = 0;
    req.b_ready = 1'b1;
    do begin @(negedge clk); k++; end while (!rsp.b_valid && k < 50);
    if (!rsp.b_valid) timeout("b_handshake");
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input bit toggle);
    model_read(id, a, len, burst, size);
    set_ar(id, a, len, burst, size);
    ar_wait();
    r_collect(len + 1, toggle);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
    model_write(id, a, len, burst, size);
    set_aw(id, a, len, burst, size);
    aw_wait();
    w_phase(len);
    b_phase();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_arready"}, rsp.ar_ready, 0);
    chk({tag, "_awready"}, rsp.aw_ready, 0);
    chk({tag, "_wready"}, rsp.w_ready, 0);
    chk({tag, "_rvalid"}, rsp.r_valid, 0);
    chk({tag, "_bvalid"}, rsp.b_valid, 0);
    chk({tag, "_sram_req"}, sram_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=no_finish required=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    req = '0;
    for (int i = 0; i < int'(MW); i++) ref_mem[i] = init_word(i);

    @(negedge clk);
    check_quiet("reset");
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single read of word 4: strobe at N+1, data at N+2
    do_read(4'd3, 32'h10, 0, BURST_INCR, 3'd2, 1'b0);
    chk("lat_sram_req", 32'(sreq_cyc), 32'(ar_cyc + 1));
    chk("lat_rvalid", 32'(rv_cyc), 32'(ar_cyc + 2));
    chk("single_rdata", last_rdata, 32'hDEADBEEF);
    chk("single_rid", last_rid, 4'd3);
    chk("single_rlast", last_rlast, 1'b1);
    chk("single_rresp", last_rresp, RESP_OKAY);

    // Partial-strobe write to word 8, then read back
    wd[0] = 32'h12345678; ws[0] = 4'b0011; wl[0] = 1'b1;
    do_write(4'd4, 32'h20, 0, BURST_INCR, 3'd2);
    chk("wr_bresp", last_bresp, RESP_OKAY);
    chk("wr_bid", last_bid, 4'd4);
    chk("model_word8", ref_mem[8], 32'hC0DE5678);
    do_read(4'd4, 32'h20, 0, BURST_INCR, 3'd2, 1'b0);
    chk("wr_readback", last_rdata, 32'hC0DE5678);

    // INCR burst of 4 with rready toggling
    do_read(4'd5, 32'h100, 3, BURST_INCR, 3'd2, 1'b1);
    chk("incr_last_data", last_rdata, 32'hC0DE0043);
    chk("incr_rlast", last_rlast, 1'b1);

    // FIXED burst rereads the same word
    do_read(4'd6, 32'h10, 2, BURST_FIXED, 3'd2, 1'b0);
    chk("fixed_rdata", last_rdata, 32'hDEADBEEF);

    // Full-strobe INCR write burst, read back with stalls
    wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    wl[0] = 1'b0; wl[1] = 1'b0; wl[2] = 1'b1;
    do_write(4'd9, 32'h300, 2, BURST_INCR, 3'd2);
    chk("burst_bresp", last_bresp, RESP_OKAY);
    do_read(4'd9, 32'h300, 2, BURST_INCR, 3'd2, 1'b1);
    chk("burst_readback", last_rdata, 32'h33333333);

    // Error cases
    do_read(4'd1, 32'(MW * 4), 0, BURST_INCR, 3'd2, 1'b0);
    chk("oob_rresp", last_rresp, RESP_SLVERR);
    do_read(4'd2, 32'h40, 1, BURST_WRAP, 3'd2, 1'b0);
    chk("wrap_rresp", last_rresp, RESP_SLVERR);
    chk("wrap_rlast", last_rlast, 1'b1);
    do_read(4'd7, 32'(MW * 4 - 8), 3, BURST_INCR, 3'd2, 1'b0);
    chk("edge_rresp_last", last_rresp, RESP_SLVERR);
    wd[0] = 32'hA1A2A3A4; wd[1] = 32'hB1B2B3B4; ws[0] = 4'hF; ws[1] = 4'hF;
    wl[0] = 1'b1; wl[1] = 1'b0;
    do_write(4'd8, 32'h80, 1, BURST_INCR, 3'd2);
    chk("early_wlast_bresp", last_bresp, RESP_SLVERR);
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(4'd10, 32'h40, 0, BURST_INCR, 3'd1);
    chk("bad_size_bresp", last_bresp, RESP_SLVERR);

    // Reset in the middle of a 4-beat read response
    begin
      int k = 0;
      model_read(4'd11, 32'h200, 3, BURST_INCR, 3'd2);
      set_ar(4'd11, 32'h200, 3, BURST_INCR, 3'd2);
      ar_wait();
      req.r_ready = 1'b0;
      do begin @(negedge clk); k++; end while (!rsp.r_valid && k < 20);
      if (!rsp.r_valid) timeout("rst_wait_rvalid");
      #2 rst_n = 1'b0;
      rq.delete();
      sq.delete();
      #1;
      check_quiet("midrst");
      @(negedge clk);
      check_quiet("midrst_hold");
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end

    // Arbitration right after reset: read first, then the held write, then a read
    begin
      model_read(4'd1, 32'h30, 0, BURST_INCR, 3'd2);
      wd[0] = 32'hFEEDF00D; ws[0] = 4'hF; wl[0] = 1'b1;
      model_write(4'd2, 32'h34, 0, BURST_INCR, 3'd2);
      model_read(4'd3, 32'h34, 0, BURST_INCR, 3'd2);
      set_ar(4'd1, 32'h30, 0, BURST_INCR, 3'd2);
      set_aw(4'd2, 32'h34, 0, BURST_INCR, 3'd2);
      @(negedge clk);
      chk("arb1_arready", rsp.ar_ready, 1'b1);
      chk("arb1_awready", rsp.aw_ready, 1'b0);
      @(posedge clk); #1;
      req.ar_valid = 1'b0;
      r_collect(1, 1'b0);
      chk("arb1_rdata", last_rdata, 32'hC0DE000C);
      set_ar(4'd3, 32'h34, 0, BURST_INCR, 3'd2);
      @(negedge clk);
      chk("arb2_awready", rsp.aw_ready, 1'b1);
      chk("arb2_arready", rsp.ar_ready, 1'b0);
      @(posedge clk); #1;
      req.aw_valid = 1'b0;
      w_phase(0);
      b_phase();
      chk("arb2_bid", last_bid, 4'd2);
      ar_wait();
      r_collect(1, 1'b0);
      chk("arb3_rdata", last_rdata, 32'hFEEDF00D);
      chk("arb3_rid", last_rid, 4'd3);
    end

    repeat (3) @(posedge clk);
    chk("rq_drained", 32'(rq.size()), 32'h0);
    chk("sq_drained", 32'(sq.size()), 32'h0);
    chk("bq_drained", 32'(bq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
